mem_copy_master: RTL and testbench
==================================

# mem_copy_master

Word-copy DMA initiator for the single-cycle ARM data-memory bus. When started, it issues its own reads and writes on that bus using the same address map and access rules as the ARM core: asynchronous read, and a write committed on the CLK edge while MemWrite is high. It copies LEN words from a source region, constant or variable data memory, into variable data memory. This lets the top level initialise or snapshot DATA_VAR_MEM without running instructions. The top level muxes its bus outputs against the core's while BUSY is high.

## Interface
- CONST_BASE, 32'h00000200, lowest constant-memory word address
- CONST_TOP, 32'h000003FC, highest constant-memory word address
- VAR_BASE, 32'h00000800, lowest variable-memory word address
- VAR_TOP, 32'h000009FC, highest variable-memory word address
- CLK  in  1  single clock; all state changes on posedge
- RESET  in  1  synchronous, active-high
- START  in  1  request; sampled only in IDLE
- SRC_ADDR  in  32  source byte address of word 0
- DST_ADDR  in  32  destination byte address of word 0
- LEN  in  8  word count, 0..128
- BUSY  out  1  high in READ and WRITE states
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  high only with DONE, when the request was rejected
- MemAddr  out  32  bus address (replaces ALUResult)
- MemWrite  out  1  write strobe
- WriteData  out  32  write data
- ReadData  in  32  combinational read data for MemAddr

## Operation
- States: IDLE, READ, WRITE, FIN.
- Registers:
  - src_r, dst_r (32 bits each)
  - len_r (8 bits)
  - idx (8 bits, word counter)
  - buf_r (32 bits)
  - err_r
- IDLE:
  - On START=1, latch SRC_ADDR, DST_ADDR and LEN, and clear idx.
  - Validate the request in the same cycle:
    - SRC_ADDR[1:0] and DST_ADDR[1:0] must be 0.
    - The source span [SRC_ADDR, SRC_ADDR+4*(LEN-1)] must lie entirely inside [CONST_BASE, CONST_TOP] or entirely inside [VAR_BASE, VAR_TOP].
    - The destination span must lie entirely inside [VAR_BASE, VAR_TOP].
    - LEN must be ≤ 128.
  - Compute span ends at 33-bit width, so overflow fails the check.
  - If validation fails: err_r=1, go to FIN.
  - If LEN=0: err_r=0, go to FIN. No bus activity.
  - Otherwise: err_r=0, go to READ.
- READ:
  - MemAddr = src_r + 4*idx, MemWrite=0.
  - At the edge, buf_r <= ReadData; go to WRITE.
- WRITE:
  - MemAddr = dst_r + 4*idx, MemWrite=1, WriteData=buf_r.
  - At the edge, idx <= idx+1.
  - If idx+1 == len_r, go to FIN; else go to READ.
- FIN: DONE=1, ERR=err_r; go to IDLE next edge.
- IDLE outputs: MemAddr=0, MemWrite=0, WriteData=0.
- MemWrite is a decode of the state register only. It never goes high outside WRITE.
- Copy order is ascending. For overlapping regions with src < dst, the copy is a forward copy: repeated data propagates. This behaviour is specified, not an error.
- START while not in IDLE is ignored; there is no queueing.
- LEN = 128 is legal. idx holds 0..128 without wrap.

## Timing
- Reset values: BUSY=0, DONE=0, ERR=0, MemWrite=0, MemAddr=0, WriteData=0, state=IDLE, idx=0, buf_r=0.
- RESET has priority over everything. If asserted mid-transfer, the block is in IDLE after that edge and MemWrite is 0.
  - Words already written stay written.
  - No DONE pulse is issued for the aborted transfer.
- START high at edge E0, valid request, LEN=N>0:
  - Cycles E0..E1 through E(2N-1)..E(2N) alternate READ and WRITE.
  - FIN occupies cycle E(2N)..E(2N+1).
  - Total latency from START to DONE is 2N+1 cycles.
- Invalid request or LEN=0: DONE (and ERR if invalid) is high in the cycle right after the START edge.
- BUSY falls as DONE rises. A new START is accepted at the edge that ends FIN+1, i.e. once the state is back in IDLE.
- Bus timing: a write commits at the edge that ends its WRITE cycle. The read data for word i is therefore never affected by the write of word i. It is affected by earlier writes only in the overlap case.

## Test plan
- Const-to-var copy: preload DATA_CONST_MEM[6..8] = 40B00000, 40D80000, 426A0000. START with SRC=0x218, DST=0x810, LEN=3.
  - DONE rises 7 cycles after START, ERR=0.
  - DATA_VAR_MEM[4..6] hold the three values.
  - MemWrite is high in exactly 3 cycles.
- LEN=0, SRC=0x200, DST=0x800: DONE=1, ERR=0 in the next cycle; MemWrite is never high.
- Rejected requests, each giving DONE=ERR=1 in 1 cycle with no writes:
  - DST=0x3F0 (outside variable memory).
  - SRC=0x201 (unaligned).
  - DST=0x9F8 with LEN=3 (span crosses VAR_TOP).
- Overlap: var[0..3] = 1,2,3,4. SRC=0x800, DST=0x804, LEN=3. Result: var[0..3] = 1,1,1,1.
- RESET after the second WRITE of an LEN=5 copy:
  - State goes to IDLE; MemWrite and BUSY are 0 after that edge.
  - Exactly 2 destination words are changed; no DONE pulse.
- START pulsed again while BUSY (LEN=4 copy) is ignored. Exactly one DONE appears, at cycle 9 after the first START.

Source files
------------

// File: rtl/mem_copy_master.sv
// Word-copy DMA initiator for the single-cycle data-memory bus: validates a
// request, then alternates READ/WRITE cycles to copy LEN words in ascending order.
module mem_copy_master (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] SRC_ADDR,
    input  logic [31:0] DST_ADDR,
    input  logic [7:0]  LEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [31:0] MemAddr,
    output logic        MemWrite,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam logic [32:0] CONST_BASE = 33'h0_0000_0200;
    localparam logic [32:0] CONST_TOP  = 33'h0_0000_03FC;
    localparam logic [32:0] VAR_BASE   = 33'h0_0000_0800;
    localparam logic [32:0] VAR_TOP    = 33'h0_0000_09FC;

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    state_t      state, state_nx;
    logic [31:0] src_r, dst_r, buf_r;
    logic [7:0]  len_r, idx;
    logic        err_r;

    // Span ends are formed at 33 bits so a wrap past 4 GiB lands above every TOP.
    logic [7:0]  last_off;
    logic [32:0] span_off, src_lo, src_hi, dst_lo, dst_hi;
    logic        aligned, src_in, dst_in, req_ok, last_word;
    logic [31:0] word_off;

    assign last_off = (LEN == 8'd0) ? 8'd0 : LEN - 8'd1;
    assign span_off = {23'd0, last_off, 2'b00};
    assign src_lo   = {1'b0, SRC_ADDR};
    assign src_hi   = src_lo + span_off;
    assign dst_lo   = {1'b0, DST_ADDR};
    assign dst_hi   = dst_lo + span_off;

    assign aligned  = (SRC_ADDR[1:0] == 2'b00) && (DST_ADDR[1:0] == 2'b00);
    assign src_in   = (src_lo >= CONST_BASE && src_hi <= CONST_TOP) ||
                      (src_lo >= VAR_BASE   && src_hi <= VAR_TOP);
    assign dst_in   = (dst_lo >= VAR_BASE) && (dst_hi <= VAR_TOP);
    assign req_ok   = aligned && src_in && dst_in && (LEN <= 8'd128);

    assign last_word = ({1'b0, idx} + 9'd1) == {1'b0, len_r};
    assign word_off  = {22'd0, idx, 2'b00};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nx  = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        ERR       = 1'b0;
        MemAddr   = 32'h0;
        MemWrite  = 1'b0;
        WriteData = 32'h0;
        unique case (state)
            IDLE: begin
                if (START) begin
                    if (!req_ok)            state_nx = FIN;
                    else if (LEN == 8'd0)   state_nx = FIN;
                    else                    state_nx = READ;
                end
            end
            READ: begin
                BUSY     = 1'b1;
                MemAddr  = src_r + word_off;
                state_nx = WRITE;
            end
            WRITE: begin
                BUSY      = 1'b1;
                MemAddr   = dst_r + word_off;
                MemWrite  = 1'b1;
                WriteData = buf_r;
                state_nx  = last_word ? FIN : READ;
            end
            FIN: begin
                DONE     = 1'b1;
                ERR      = err_r;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET) begin
            state <= IDLE;
            src_r <= 32'h0;
            dst_r <= 32'h0;
            len_r <= 8'd0;
            idx   <= 8'd0;
            buf_r <= 32'h0;
            err_r <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        src_r <= SRC_ADDR;
                        dst_r <= DST_ADDR;
                        len_r <= LEN;
                        idx   <= 8'd0;
                        err_r <= !req_ok;
                    end
                end
                READ:    buf_r <= ReadData;
                WRITE:   idx   <= idx + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Randomised and directed bench for mem_copy_master: a bus memory model, a word-level
// reference copy, and a scoreboard monitor that checks every DONE pulse.
module tb_mem_copy_master;

    logic        CLK = 1'b0;
    logic        RESET, START;
    logic [31:0] SRC_ADDR, DST_ADDR;
    logic [7:0]  LEN;
    logic        BUSY, DONE, ERR, MemWrite;
    logic [31:0] MemAddr, WriteData, ReadData;

    mem_copy_master dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .MemAddr(MemAddr), .MemWrite(MemWrite), .WriteData(WriteData),
        .ReadData(ReadData)
    );

    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cnt = 0;
    always @(posedge CLK) cnt <= cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bus memories ----------------
    logic [31:0] const_mem [0:127];
    logic [31:0] var_mem   [0:127];
    logic        poke_en = 1'b0;
    logic [6:0]  poke_idx = 7'd0;
    logic [31:0] poke_data = 32'h0;
    int unsigned stray_wr = 0;

    always_comb begin
        ReadData = 32'h0;
        if (MemAddr >= 32'h200 && MemAddr <= 32'h3FF)      ReadData = const_mem[MemAddr[8:2]];
        else if (MemAddr >= 32'h800 && MemAddr <= 32'h9FF) ReadData = var_mem[MemAddr[8:2]];
    end

    always @(posedge CLK) begin
        if (poke_en) var_mem[poke_idx] <= poke_data;
        else if (MemWrite) begin
            if (MemAddr >= 32'h800 && MemAddr <= 32'h9FF && MemAddr[1:0] == 2'b00)
                var_mem[MemAddr[8:2]] <= WriteData;
            else
                stray_wr <= stray_wr + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_var [0:127];

    function automatic bit req_valid(input logic [31:0] s, input logic [31:0] d, input int l);
        longint s0 = longint'(s);
        longint d0 = longint'(d);
        longint span = 4 * ((l == 0) ? 0 : l - 1);
        bit src_ok = (s0 >= 'h200 && s0 + span <= 'h3FC) || (s0 >= 'h800 && s0 + span <= 'h9FC);
        bit dst_ok = (d0 >= 'h800 && d0 + span <= 'h9FC);
        return (s[1:0] == 2'b00) && (d[1:0] == 2'b00) && (l <= 128) && src_ok && dst_ok;
    endfunction

    function automatic logic [31:0] ref_rd(input longint a);
        if (a >= 'h200 && a <= 'h3FC) return const_mem[int'((a - 'h200) / 4)];
        return ref_var[int'((a - 'h800) / 4)];
    endfunction

    typedef struct {
        logic        err;
        int unsigned lat;
        int unsigned writes;
        int unsigned c0;
    } exp_t;
    exp_t sb[$];

    // Updates the reference image; optionally copies only the first n_words (abort case).
    task automatic model_req(input logic [31:0] s, input logic [31:0] d, input int l,
                             input bit push, input int n_words);
        exp_t e;
        bit ok = req_valid(s, d, l);
        e.err    = !ok;
        e.lat    = (ok && l > 0) ? 2 * l + 1 : 1;
        e.writes = ok ? l : 0;
        e.c0     = cnt;
        if (push) sb.push_back(e);
        if (ok)
            for (int i = 0; i < l && i < n_words; i++)
                ref_var[int'((longint'(d) - 'h800) / 4) + i] = ref_rd(longint'(s) + 4 * i);
    endtask

    // ---------------- monitor ----------------
    int unsigned wr_cnt = 0;
    int unsigned bad_strobe = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (RESET) begin
            wr_cnt     = 0;
            bad_strobe = 0;
        end else begin
            if (MemWrite) wr_cnt++;
            if (MemWrite && !BUSY) bad_strobe++;
            if (!DONE) check("err_without_done", ERR, 1'b0);
            if (DONE) begin
                if (sb.size() == 0) check("unexpected_done", DONE, 1'b0);
                else begin
                    e = sb.pop_front();
                    check("err", ERR, e.err);
                    check("latency", cnt - e.c0, e.lat);
                    check("write_cycles", wr_cnt, e.writes);
                    check("strobe_outside_busy", bad_strobe, 0);
                    check("busy_with_done", BUSY, 1'b0);
                end
                wr_cnt     = 0;
                bad_strobe = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic poke(input int i, input logic [31:0] v);
        poke_en = 1'b1; poke_idx = 7'(i); poke_data = v;
        ref_var[i] = v;
        tick(1);
        poke_en = 1'b0;
    endtask

    task automatic drive_start(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
        START = 1'b1; SRC_ADDR = s; DST_ADDR = d; LEN = l;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        tick(2);
    endtask

    task automatic check_mem();
        int bad = 0;
        for (int i = 0; i < 128; i++) if (var_mem[i] !== ref_var[i]) bad++;
        check("var_mem_mismatches", bad, 0);
    endtask

    task automatic run_req(input logic [31:0] s, input logic [31:0] d, input int l);
        drive_start(s, d, 8'(l));
        model_req(s, d, l, 1'b1, 256);
        tick(1);
        START = 1'b0;
        wait_done();
        check_mem();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET = 1'b1; START = 1'b0; SRC_ADDR = 32'h0; DST_ADDR = 32'h0; LEN = 8'd0;
        for (int i = 0; i < 128; i++) const_mem[i] = $urandom;
        tick(3);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_err", ERR, 1'b0);
        check("rst_memwrite", MemWrite, 1'b0);
        check("rst_memaddr", MemAddr, 32'h0);
        check("rst_writedata", WriteData, 32'h0);
        RESET = 1'b0;
        for (int i = 0; i < 128; i++) poke(i, $urandom);
        tick(1);

        const_mem[6] = 32'h40B00000;
        const_mem[7] = 32'h40D80000;
        const_mem[8] = 32'h426A0000;
        run_req(32'h218, 32'h810, 3);
        check("const_copy_w4", var_mem[4], 32'h40B00000);
        check("const_copy_w6", var_mem[6], 32'h426A0000);

        run_req(32'h200, 32'h800, 0);
        run_req(32'h200, 32'h3F0, 1);
        run_req(32'h201, 32'h800, 1);
        run_req(32'h200, 32'h9F8, 3);
        run_req(32'hFFFFFFFC, 32'h800, 2);
        run_req(32'h200, 32'h800, 129);

        for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));
        run_req(32'h800, 32'h804, 3);
        check("overlap_w3", var_mem[3], 32'h1);

        run_req(32'h200, 32'h800, 128);
        run_req(32'h800 + 4 * 127, 32'h800, 1);

        // Abort: RESET sampled at the edge after the second write commits.
        drive_start(32'h240, 32'h900, 8'd5);
        model_req(32'h240, 32'h900, 5, 1'b0, 2);
        tick(1);
        START = 1'b0;
        tick(4);
        RESET = 1'b1;
        tick(1);
        check("abort_busy", BUSY, 1'b0);
        check("abort_memwrite", MemWrite, 1'b0);
        check("abort_done", DONE, 1'b0);
        RESET = 1'b0;
        tick(20);
        check_mem();

        // A second START while busy must be ignored.
        drive_start(32'h260, 32'h880, 8'd4);
        model_req(32'h260, 32'h880, 4, 1'b1, 256);
        tick(1);
        START = 1'b0;
        tick(2);
        drive_start(32'h200, 32'h9F0, 8'd1);
        tick(1);
        START = 1'b0;
        wait_done();
        tick(10);
        check_mem();

        for (int t = 0; t < 40; t++) begin
            int l;
            logic [31:0] s, d;
            l = ($urandom_range(0, 5) == 0) ? int'($urandom_range(100, 140)) : int'($urandom_range(0, 24));
            case ($urandom_range(0, 5))
                0, 1, 2: s = 32'h200 + 4 * $urandom_range(0, 127);
                3, 4:    s = 32'h800 + 4 * $urandom_range(0, 127);
                default: s = $urandom;
            endcase
            d = ($urandom_range(0, 7) == 0) ? 32'h7F0 + $urandom_range(0, 40)
                                            : 32'h800 + 4 * $urandom_range(0, 127);
            if (l == 0) begin
                s = 32'h200 + 4 * $urandom_range(0, 127);
                d = 32'h800 + 4 * $urandom_range(0, 127);
            end
            run_req(s, d, l);
        end

        check("scoreboard_empty", sb.size(), 0);
        check("stray_writes", stray_wr, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
